// File: rtl/ospi_ram_arbiter_if.sv
// Signal bundle between the OSPI host front-end, the local burst requester and the
// single-port buffer RAM. The arbiter takes the slave view; the surroundings take master.
interface ospi_ram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 8
);
  logic              h_active;
  logic              h_we;
  logic              h_re;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [DATA_W-1:0] h_rdata;

  logic              l_cmd_valid;
  logic              l_cmd_ready;
  logic              l_cmd_we;
  logic [ADDR_W-1:0] l_cmd_addr;
  logic [LEN_W-1:0]  l_cmd_len;
  logic [DATA_W-1:0] l_wdata;
  logic              l_wvalid;
  logic              l_wready;
  logic [DATA_W-1:0] l_rdata;
  logic              l_rvalid;
  logic              l_rready;
  logic              l_done;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  h_active, h_we, h_re, h_addr, h_wdata,
    input  l_cmd_valid, l_cmd_we, l_cmd_addr, l_cmd_len, l_wdata, l_wvalid, l_rready,
    input  ram_rdata,
    output h_rdata, l_cmd_ready, l_wready, l_rdata, l_rvalid, l_done,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output h_active, h_we, h_re, h_addr, h_wdata,
    output l_cmd_valid, l_cmd_we, l_cmd_addr, l_cmd_len, l_wdata, l_wvalid, l_rready,
    output ram_rdata,
    input  h_rdata, l_cmd_ready, l_wready, l_rdata, l_rvalid, l_done,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ospi_ram_arbiter.sv
// Shares the single-port OSPI buffer RAM between the host front-end, which always wins,
// and a local burst engine that streams bytes through the cycles the host leaves idle.
module ospi_ram_arbiter #(
  parameter int ADDR_W         = 18,
  parameter int LEN_W          = 16,
  parameter int DATA_W         = 8,
  parameter bit LOCK_ON_ACTIVE = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  ospi_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  remain, remain_nxt;
  logic              host_acc, blocked;
  logic              wr_fire, rd_issue, rd_pop, credit;
  logic              vld_p1;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occupancy;

  assign host_acc = bus.h_we | bus.h_re;
  assign blocked  = host_acc | (LOCK_ON_ACTIVE & bus.h_active);

  // Bytes that will sit in the FIFO after this edge: queued + returning - popped.
  assign rd_pop    = bus.l_rvalid & bus.l_rready;
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, rd_pop};
  assign credit    = occupancy < 3'd2;

  assign bus.l_rvalid = fifo_cnt != 2'd0;
  assign bus.l_rdata  = fifo_mem[rd_ptr];
  assign bus.h_rdata  = bus.ram_rdata;

  always_comb begin
    state_nxt       = state;
    cur_addr_nxt    = cur_addr;
    remain_nxt      = remain;
    wr_fire         = 1'b0;
    rd_issue        = 1'b0;
    bus.l_cmd_ready = 1'b0;
    bus.l_wready    = 1'b0;
    bus.l_done      = 1'b0;
    bus.ram_en      = host_acc;
    bus.ram_we      = bus.h_we;
    bus.ram_addr    = bus.h_addr;
    bus.ram_wdata   = bus.h_wdata;
    unique case (state)
      IDLE: begin
        bus.l_cmd_ready = 1'b1;
        if (bus.l_cmd_valid) begin
          cur_addr_nxt = bus.l_cmd_addr;
          remain_nxt   = bus.l_cmd_len;
          if (bus.l_cmd_len == '0) state_nxt = DONE;
          else if (bus.l_cmd_we)   state_nxt = WR;
          else                     state_nxt = RD;
        end
      end
      WR: begin
        bus.l_wready = ~blocked;
        wr_fire      = bus.l_wvalid & ~blocked;
        if (wr_fire) begin
          bus.ram_en    = 1'b1;
          bus.ram_we    = 1'b1;
          bus.ram_addr  = cur_addr;
          bus.ram_wdata = bus.l_wdata;
          cur_addr_nxt  = cur_addr + ADDR_W'(1);
          remain_nxt    = remain - LEN_W'(1);
          if (remain == LEN_W'(1)) state_nxt = DONE;
        end
      end
      RD: begin
        rd_issue = ~blocked & (remain != '0) & credit;
        if (rd_issue) begin
          bus.ram_en   = 1'b1;
          bus.ram_we   = 1'b0;
          bus.ram_addr = cur_addr;
          cur_addr_nxt = cur_addr + ADDR_W'(1);
          remain_nxt   = remain - LEN_W'(1);
        end
        if ((remain == '0) && !vld_p1 && (occupancy == 3'd0)) state_nxt = DONE;
      end
      DONE: begin
        bus.l_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: issued read in flight through the registered RAM read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
      vld_p1   <= 1'b0;
      fifo_cnt <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_addr <= cur_addr_nxt;
      remain   <= remain_nxt;
      vld_p1   <= rd_issue;
      fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, rd_pop};
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (rd_pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Stage p1 -> FIFO: returning RAM byte is captured; storage needs no reset
  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[wr_ptr] <= bus.ram_rdata;
  end
endmodule

// File: tb/tb_ospi_ram_arbiter.sv
// Randomised bench for ospi_ram_arbiter: a RAM model, a host/local driver and a
// scoreboard monitor checking every RAM access and stream byte against a reference memory.
module tb_ospi_ram_arbiter;
  localparam int ADDR_W = 18;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 8;
  localparam int MEM_N  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] HOST_BASE = 18'h20000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ospi_ram_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();
  ospi_ram_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .LOCK_ON_ACTIVE(1'b1))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37) ^ (a >> 9) ^ 32'h5A);
  endfunction

  // RAM with registered read; preloaded with a known pattern on the first edge
  logic [7:0] ram [MEM_N];
  logic ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < MEM_N; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= ram[bus.ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  logic [7:0]        ref_mem [MEM_N];
  logic [ADDR_W-1:0] lw_a [$];
  logic [7:0]        lw_d [$];
  logic [ADDR_W-1:0] la_q [$];
  logic [7:0]        rd_q [$];
  logic [ADDR_W-1:0] hw_q [$];
  int issued = 0, popped = 0, loc_acc_cnt = 0;
  int last_pop = -1, first_iss = -1, first_pop = -1, lat_arm = 0;
  bit hr_pend = 1'b0;
  logic [7:0] hr_exp;
  bit host_acc;

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      lw_a.delete(); lw_d.delete(); la_q.delete(); rd_q.delete();
      issued = 0; popped = 0; hr_pend = 1'b0;
    end else begin
      host_acc = bus.h_we | bus.h_re;
      if (hr_pend) chk("h_rdata", bus.h_rdata, hr_exp);
      hr_pend = 1'b0;
      if (host_acc) begin
        chk("host_ram_en", bus.ram_en, 1);
        chk("host_ram_we", bus.ram_we, bus.h_we);
        chk("host_ram_addr", bus.ram_addr, bus.h_addr);
        if (bus.h_we) chk("host_ram_wdata", bus.ram_wdata, bus.h_wdata);
      end
      if (host_acc || bus.h_active) chk("blocked_wready", bus.l_wready, 0);
      if (bus.ram_en && !host_acc) begin
        loc_acc_cnt++;
        chk("local_while_active", bus.h_active, 0);
        if (bus.ram_we) begin
          chk("local_write_expected", lw_a.size() > 0, 1);
          if (lw_a.size() > 0) begin
            chk("local_write_addr", bus.ram_addr, lw_a.pop_front());
            chk("local_write_data", bus.ram_wdata, lw_d.pop_front());
          end
        end else begin
          chk("local_read_expected", la_q.size() > 0, 1);
          if (la_q.size() > 0) chk("local_read_addr", bus.ram_addr, la_q.pop_front());
          issued++;
          if (lat_arm == 1) begin first_iss = cyc; lat_arm = 2; end
        end
      end
      if (bus.l_rvalid && bus.l_rready) begin
        chk("rd_data_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) chk("l_rdata", bus.l_rdata, rd_q.pop_front());
        popped++;
        last_pop = cyc;
        if (lat_arm == 2) begin first_pop = cyc; lat_arm = 3; end
      end
      if (issued != popped) chk("fifo_no_overflow", (issued - popped) <= 2, 1);
      if (bus.h_re && !bus.h_we) begin hr_pend = 1'b1; hr_exp = ref_mem[bus.h_addr]; end
      if (bus.h_we) ref_mem[bus.h_addr] = bus.h_wdata;
    end
  end

  int host_mode = 0;
  int host_left = 0;

  function automatic logic [ADDR_W-1:0] host_addr();
    return HOST_BASE | ADDR_W'($urandom_range(0, 255));
  endfunction

  task automatic drive_host();
    int r;
    bus.h_we = 1'b0; bus.h_re = 1'b0; bus.h_active = 1'b0;
    r = $urandom_range(0, 7);
    case (host_mode)
      1: if (host_left > 0) begin
        bus.h_active = 1'b1; bus.h_we = 1'b1;
        bus.h_addr = host_addr(); bus.h_wdata = 8'($urandom);
        hw_q.push_back(bus.h_addr);
        host_left--;
      end
      2: if (r < 3) begin
        bus.h_active = 1'b1; bus.h_re = 1'b1; bus.h_addr = host_addr();
      end
      3: begin
        bus.h_addr = host_addr(); bus.h_wdata = 8'($urandom);
        if (r == 0)      begin bus.h_active = 1'b1; bus.h_we = 1'b1; end
        else if (r == 1) begin bus.h_active = 1'b1; bus.h_re = 1'b1; end
        else if (r == 2) bus.h_active = 1'b1;
        else if (r == 3) begin bus.h_active = 1'b1; bus.h_we = 1'b1; bus.h_re = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic begin_cycle();
    @(posedge clk); #1;
    drive_host();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] addr, input int len,
                          output int acc);
    int n;
    n = 0;
    begin_cycle();
    bus.l_cmd_valid = 1'b1; bus.l_cmd_we = we;
    bus.l_cmd_addr = addr; bus.l_cmd_len = LEN_W'(len);
    sample();
    while (!bus.l_cmd_ready && n < 50) begin begin_cycle(); sample(); n++; end
    chk("cmd_accept", bus.l_cmd_ready, 1);
    acc = cyc;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input int len, input bit gaps,
                          input bit lat_chk);
    logic [7:0] d [$];
    logic [ADDR_W-1:0] a;
    int acc, idx, first, last, done, n;
    bit pend;
    idx = 0; first = -1; last = -1; done = -1; n = 0; pend = 1'b0;
    for (int i = 0; i < len; i++) d.push_back(lat_chk ? 8'(8'hA0 + i) : 8'($urandom));
    send_cmd(1'b1, addr, len, acc);
    for (int i = 0; i < len; i++) begin
      a = addr + ADDR_W'(i);
      lw_a.push_back(a); lw_d.push_back(d[i]); ref_mem[a] = d[i];
    end
    while (done < 0 && n < 400) begin
      begin_cycle();
      bus.l_cmd_valid = 1'b0;
      if (!pend && idx < len) pend = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.l_wvalid = pend;
      bus.l_wdata = (idx < len) ? d[idx] : 8'h00;
      sample();
      chk("busy_cmd_ready", bus.l_cmd_ready, 0);
      if (bus.l_done) done = cyc;
      else if (pend && bus.l_wready) begin
        if (first < 0) first = cyc;
        last = cyc; idx++; pend = 1'b0;
      end
      n++;
    end
    chk("wr_done_seen", done >= 0, 1);
    chk("wr_bytes", idx, len);
    chk("wr_done_timing", done, (len == 0) ? acc + 1 : last + 1);
    if (lat_chk) chk("wr_throughput", last - first, len - 1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input int len, input int rmode,
                         input bit lat_chk);
    logic [ADDR_W-1:0] a;
    int acc, done, n, pops0;
    done = -1; n = 0;
    send_cmd(1'b0, addr, len, acc);
    pops0 = popped;
    for (int i = 0; i < len; i++) begin
      a = addr + ADDR_W'(i);
      la_q.push_back(a); rd_q.push_back(ref_mem[a]);
    end
    lat_arm = lat_chk ? 1 : 0;
    while (done < 0 && n < 400) begin
      begin_cycle();
      bus.l_cmd_valid = 1'b0;
      if (rmode == 0)      bus.l_rready = 1'b1;
      else if (rmode == 1) bus.l_rready = (n % 2) == 0;
      else                 bus.l_rready = 1'($urandom_range(0, 1));
      sample();
      chk("busy_cmd_ready", bus.l_cmd_ready, 0);
      if (bus.l_done) done = cyc;
      n++;
    end
    chk("rd_done_seen", done >= 0, 1);
    chk("rd_bytes", popped - pops0, len);
    if (len > 0) chk("rd_done_timing", done, last_pop + 1);
    else         chk("len0_done_timing", done, acc + 1);
    if (lat_chk) begin
      chk("rd_first_issue", first_iss, acc + 1);
      chk("rd_first_latency", first_pop - first_iss, 2);
      chk("rd_stream_rate", last_pop - first_pop, len - 1);
    end
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] addr);
    begin_cycle();
    bus.h_active = 1'b1; bus.h_re = 1'b1; bus.h_addr = addr;
    sample();
  endtask

  task automatic reset_mid_read();
    int acc;
    logic [ADDR_W-1:0] a;
    send_cmd(1'b0, 18'h00040, 8, acc);
    for (int i = 0; i < 8; i++) begin
      a = 18'h00040 + ADDR_W'(i);
      la_q.push_back(a); rd_q.push_back(ref_mem[a]);
    end
    for (int i = 0; i < 6; i++) begin
      begin_cycle(); bus.l_cmd_valid = 1'b0; bus.l_rready = 1'b0; sample();
    end
    chk("rd_queued_before_reset", bus.l_rvalid, 1);
    begin_cycle(); reset_n = 1'b0; sample();
    begin_cycle(); sample();
    begin_cycle(); reset_n = 1'b1; sample();
    chk("post_reset_rvalid", bus.l_rvalid, 0);
    chk("post_reset_cmd_ready", bus.l_cmd_ready, 1);
    chk("post_reset_done", bus.l_done, 0);
    for (int i = 0; i < 4; i++) begin
      begin_cycle(); bus.l_rready = 1'b1; sample();
      chk("no_done_after_reset", bus.l_done, 0);
      chk("idle_after_reset", bus.l_cmd_ready, 1);
    end
  endtask

  initial begin
    int cnt0;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = pat(i);
    bus.h_active = 1'b0; bus.h_we = 1'b0; bus.h_re = 1'b0;
    bus.h_addr = '0; bus.h_wdata = '0;
    bus.l_cmd_valid = 1'b0; bus.l_cmd_we = 1'b0; bus.l_cmd_addr = '0; bus.l_cmd_len = '0;
    bus.l_wdata = '0; bus.l_wvalid = 1'b0; bus.l_rready = 1'b0;

    repeat (3) begin begin_cycle(); sample(); end
    chk("rst_cmd_ready", bus.l_cmd_ready, 1);
    chk("rst_wready", bus.l_wready, 0);
    chk("rst_rvalid", bus.l_rvalid, 0);
    chk("rst_done", bus.l_done, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    begin_cycle(); reset_n = 1'b1; sample();
    chk("idle_cmd_ready", bus.l_cmd_ready, 1);

    do_write(18'h00010, 4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) host_read(18'h00010 + ADDR_W'(i));
    begin_cycle(); sample();

    do_read(18'h00010, 8, 0, 1'b1);

    hw_q.delete();
    host_mode = 1; host_left = 16;
    do_write(18'h00080, 6, 1'b0, 1'b0);
    host_mode = 0;
    while (hw_q.size() > 0) host_read(hw_q.pop_front());
    begin_cycle(); sample();

    host_mode = 2;
    do_read(18'h00010, 12, 1, 1'b0);
    do_read(18'h00080, 10, 2, 1'b0);
    host_mode = 0;

    do_write(18'h3FFFE, 4, 1'b0, 1'b0);
    do_read(18'h3FFFE, 4, 0, 1'b0);
    cnt0 = loc_acc_cnt;
    do_write(18'h00100, 0, 1'b0, 1'b0);
    do_read(18'h00100, 0, 0, 1'b0);
    chk("len0_no_access", loc_acc_cnt - cnt0, 0);

    reset_mid_read();

    host_mode = 3;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(ADDR_W'($urandom_range(0, 511)), $urandom_range(0, 12), 1'b1, 1'b0);
      else
        do_read(ADDR_W'($urandom_range(0, 511)), $urandom_range(0, 12), 2, 1'b0);
    end
    host_mode = 0;
    for (int k = 0; k < 16; k++) host_read(ADDR_W'($urandom_range(0, 523)));
    repeat (3) begin begin_cycle(); sample(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
